// File: rtl/pb_field_serializer_arb_if.sv
// pb_field_serializer_arb_if: field request bus and encoded byte stream of the protobuf field serializer
interface pb_field_serializer_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int FIELD_W = 29
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*FIELD_W-1:0] req_field;
  logic [NUM_REQ*3-1:0] req_wtype;
  logic [NUM_REQ*64-1:0] req_value;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_data;
  logic out_last;
  logic [$clog2(NUM_REQ)-1:0] out_src;
  modport master (
    output req_valid, req_field, req_wtype, req_value, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src
  );
  modport slave (
    input  req_valid, req_field, req_wtype, req_value, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/pb_field_serializer_arb.sv
// pb_field_serializer_arb: round-robin arbiter sharing one protobuf key/value byte encoder
module pb_field_serializer_arb #(
  parameter int NUM_REQ = 4,
  parameter int FIELD_W = 29
) (
  input  logic clk,
  input  logic rst_n,
  pb_field_serializer_arb_if.slave bus,
  output logic err_pulse,
  output logic busy
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int KW = FIELD_W + 3;
  typedef enum logic [1:0] {IDLE, KEY, VAL} state_t;
  state_t state, state_nx;
  logic [SW-1:0] ptr, src, gnt;
  logic hit, bad, fire, last;
  logic [2:0] wt, cnt, w_in;
  logic [KW-1:0] k;
  logic [63:0] v, v_in;
  logic [FIELD_W-1:0] f_in;
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[(int'(ptr) + i) % NUM_REQ]) begin
        gnt = SW'((int'(ptr) + i) % NUM_REQ);
        hit = 1'b1;
      end
  end
  assign f_in = bus.req_field[gnt*FIELD_W +: FIELD_W];
  assign w_in = bus.req_wtype[gnt*3 +: 3];
  assign v_in = bus.req_value[gnt*64 +: 64];
  assign bad = f_in == '0 || (w_in != 3'd0 && w_in != 3'd1 && w_in != 3'd5);
  assign fire = bus.out_valid && bus.out_ready;
  assign last = state == VAL && (wt == 3'd0 ? v[63:7] == '0 : cnt == (wt == 3'd1 ? 3'd7 : 3'd3));
  assign bus.req_ready = (rst_n && state == IDLE && hit) ? NUM_REQ'(1) << gnt : '0;
  assign bus.out_valid = state != IDLE;
  assign bus.out_data = state == KEY ? {|k[KW-1:7], k[6:0]} :
                        state == VAL ? (wt == 3'd0 ? {|v[63:7], v[6:0]} : v[7:0]) : 8'h00;
  assign bus.out_last = last;
  assign bus.out_src = src;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    if (state == IDLE && hit && !bad) state_nx = KEY;
    else if (state == KEY && fire && k[KW-1:7] == '0) state_nx = VAL;
    else if (state == VAL && fire && last) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      src <= '0;
      wt <= '0;
      cnt <= '0;
      k <= '0;
      v <= '0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      err_pulse <= state == IDLE && hit && bad;
      if (state == IDLE && hit) begin
        ptr <= SW'((int'(gnt) + 1) % NUM_REQ);
        if (!bad) begin
          src <= gnt;
          wt <= w_in;
          cnt <= '0;
          k <= {f_in, w_in};
          v <= w_in == 3'd5 ? {32'h0, v_in[31:0]} : v_in;
        end
      end else if (fire) begin
        if (state == KEY) k <= k >> 7;
        else begin
          v <= wt == 3'd0 ? v >> 7 : v >> 8;
          cnt <= cnt + 3'd1;
        end
      end
    end
endmodule

// File: tb/tb_pb_field_serializer_arb.sv
// tb_pb_field_serializer_arb: randomized self-checking bench against a protobuf encoding model
module tb_pb_field_serializer_arb;
  localparam int N = 4;
  localparam int FW = 29;
  typedef struct {
    logic [FW-1:0] f;
    logic [2:0] w;
    logic [63:0] v;
  } item_t;
  logic clk, rst_n, err_pulse, busy;
  pb_field_serializer_arb_if #(.NUM_REQ(N), .FIELD_W(FW)) bus ();
  pb_field_serializer_arb #(.NUM_REQ(N), .FIELD_W(FW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_pulse(err_pulse),
    .busy(busy)
  );
  int n_chk = 0, n_fail = 0, nerr = 0, nbad = 0, mp = 0;
  item_t pq [N][$];
  logic [7:0] gd [$], ed [$], mq [$], lit [$];
  logic gl [$], el [$];
  int gs [$], es [$], gg [$], ord [$];
  logic [N-1:0] hs = '0;
  logic stall = 0, err_due = 0, rnd_rdy = 0;
  logic [10:0] held = '0;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic item_t mk(input logic [FW-1:0] f, input logic [2:0] w, input logic [63:0] v);
    item_t it;
    it.f = f;
    it.w = w;
    it.v = v;
    return it;
  endfunction
  function automatic bit is_bad(input item_t it);
    return it.f == 0 || !(it.w inside {3'd0, 3'd1, 3'd5});
  endfunction
  function automatic void put_varint(input logic [63:0] x);
    do begin
      mq.push_back({x > 64'd127, x[6:0]});
      x = x / 128;
    end while (x != 0);
  endfunction
  function automatic void expect_item(input int g, input item_t it);
    mq = {};
    put_varint(64'(it.f) * 8 + 64'(it.w));
    if (it.w == 3'd0) put_varint(it.v);
    else for (int i = 0; i < (it.w == 3'd1 ? 8 : 4); i++) mq.push_back(8'(it.v >> (8 * i)));
    foreach (mq[i]) begin
      ed.push_back(mq[i]);
      el.push_back(i == mq.size() - 1);
      es.push_back(g);
    end
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) if (rst_n) begin
    int e;
    check("one_hot", $countones(bus.req_ready), (!busy && bus.req_valid != 0) ? 1 : 0);
    check("ready_wo_valid", bus.req_ready & ~bus.req_valid, 0);
    if (stall && bus.out_valid) check("hold", {bus.out_src, bus.out_last, bus.out_data}, held);
    stall = bus.out_valid && !bus.out_ready;
    held = {bus.out_src, bus.out_last, bus.out_data};
    if (bus.out_valid && bus.out_ready) begin
      gd.push_back(bus.out_data);
      gl.push_back(bus.out_last);
      gs.push_back(int'(bus.out_src));
    end
    if (err_due || err_pulse) check("err_pulse", err_pulse, err_due);
    if (err_pulse) nerr++;
    err_due = 0;
    hs = bus.req_valid & bus.req_ready;
    for (int g = 0; g < N; g++) if (hs[g]) begin
      e = -1;
      for (int j = 0; j < N && e < 0; j++) if (bus.req_valid[(mp + j) % N]) e = (mp + j) % N;
      check("rr_grant", g, e);
      mp = (g + 1) % N;
      gg.push_back(g);
      if (is_bad(pq[g][0])) err_due = 1;
      else expect_item(g, pq[g][0]);
    end
  end
  task automatic run(input int budget, input int stop_bytes);
    int idle = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (hs[i]) void'(pq[i].pop_front());
      hs = '0;
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = pq[i].size() != 0;
        if (pq[i].size() != 0) begin
          bus.req_field[i*FW +: FW] = pq[i][0].f;
          bus.req_wtype[i*3 +: 3] = pq[i][0].w;
          bus.req_value[i*64 +: 64] = pq[i][0].v;
        end
      end
      if (stop_bytes > 0 && gd.size() >= stop_bytes) return;
      idle = (bus.req_valid == '0 && !busy) ? idle + 1 : 0;
      if (idle == 3) return;
    end
    check("timeout", 1, 0);
  endtask
  task automatic clr();
    gd = {}; gl = {}; gs = {}; ed = {}; el = {}; es = {}; gg = {};
    nerr = 0;
  endtask
  task automatic compare(input string tag);
    check({tag, "_len"}, gd.size(), ed.size());
    foreach (ed[i]) if (i < gd.size()) check(tag, {gs[i], gl[i], gd[i]}, {es[i], el[i], ed[i]});
  endtask
  task automatic check_lit(input string tag);
    check({tag, "_nbytes"}, gd.size(), lit.size());
    foreach (lit[i]) if (i < gd.size()) check(tag, {gl[i], gd[i]}, {i == lit.size() - 1, lit[i]});
  endtask
  task automatic check_ord(input string tag);
    check({tag, "_n"}, gg.size(), ord.size());
    foreach (ord[i]) if (i < gg.size()) check(tag, gg[i], ord[i]);
  endtask
  initial begin
    item_t it;
    int r;
    rst_n = 0;
    bus.req_valid = '0;
    bus.req_field = '0;
    bus.req_wtype = '0;
    bus.req_value = '0;
    bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {bus.out_valid, bus.out_last, bus.out_data, bus.out_src, err_pulse, busy}, 0);
    check("rst_ready", bus.req_ready, 0);
    @(negedge clk) rst_n = 1;
    clr();
    pq[0].push_back(mk(1, 0, 150));
    run(200, 0);
    lit = {8'h08, 8'h96, 8'h01};
    check_lit("t1_lit");
    compare("t1");
    clr();
    pq[1].push_back(mk(2, 1, 64'h0102030405060708));
    run(200, 0);
    lit = {8'h11, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    check_lit("t2_lit");
    compare("t2");
    clr();
    pq[2].push_back(mk(5, 5, 64'hFFFF_FFFF_DEAD_BEEF));
    run(200, 0);
    lit = {8'h2D, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_lit("t3_lit");
    compare("t3");
    clr();
    pq[3].push_back(mk('1, 0, '1));
    run(200, 0);
    lit = {8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    for (int i = 0; i < 9; i++) lit.push_back(8'hFF);
    lit.push_back(8'h01);
    check_lit("t4_lit");
    compare("t4");
    clr();
    for (int i = 0; i < N; i++) pq[i].push_back(mk(FW'(i + 3), 0, 64'(i * 1000)));
    run(500, 0);
    ord = {0, 1, 2, 3};
    check_ord("t5_order");
    compare("t5");
    clr();
    for (int i = 0; i < 2; i++) begin
      pq[0].push_back(mk(7, 5, 64'(i)));
      pq[2].push_back(mk(9, 1, 64'(i + 5)));
    end
    run(500, 0);
    ord = {0, 2, 0, 2};
    check_ord("t5_alt");
    compare("t5_alt");
    clr();
    pq[3].push_back(mk(4, 2, 64'h55));
    pq[0].push_back(mk(6, 0, 64'h300));
    run(300, 0);
    ord = {3, 0};
    check_ord("t6_bad_order");
    check("t6_err_cnt", nerr, 1);
    compare("t6_bad");
    clr();
    rnd_rdy = 1;
    pq[0].push_back(mk(1, 0, 150));
    run(500, 0);
    lit = {8'h08, 8'h96, 8'h01};
    check_lit("t6_bp_lit");
    compare("t6_bp");
    rnd_rdy = 0;
    clr();
    pq[1].push_back(mk(2, 1, 64'h0102030405060708));
    run(200, 2);
    rst_n = 0;
    #1;
    check("mid_rst_out", {bus.out_valid, bus.out_last, bus.out_data, bus.out_src, err_pulse, busy}, 0);
    check("mid_rst_ready", bus.req_ready, 0);
    for (int i = 0; i < N; i++) pq[i] = {};
    bus.req_valid = '0;
    hs = '0;
    stall = 0;
    err_due = 0;
    mp = 0;
    clr();
    @(negedge clk) rst_n = 1;
    pq[0].push_back(mk(1, 0, 150));
    pq[1].push_back(mk(5, 5, 64'hFFFF_FFFF_DEAD_BEEF));
    run(300, 0);
    ord = {0, 1};
    check_ord("t6_rst_order");
    compare("t6_rst");
    clr();
    rnd_rdy = 1;
    nbad = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      it.w = r == 0 ? 3'd2 : r == 1 ? 3'd7 : (r % 3 == 0 ? 3'd0 : r % 3 == 1 ? 3'd1 : 3'd5);
      it.f = FW'($urandom >> $urandom_range(3, 31));
      if (r == 2) it.f = 0;
      else if (it.f == 0) it.f = 1;
      it.v = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (is_bad(it)) nbad++;
      pq[$urandom_range(0, N - 1)].push_back(it);
    end
    run(60000, 0);
    check("rand_err_cnt", nerr, nbad);
    check("rand_grants", gg.size(), 300);
    compare("rand");
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
